exu_wbck: RTL and testbench

Write-back and commit stage of the NPC execution unit. Accepts completed results from the regular ALU and the LSU over valid/ready handshakes and arbitrates between them with fixed priority. Registers the winner for one cycle, drives the register-file write port, counts retired instructions and latches the ebreak halt condition for the simulation environment.

---
 rtl/exu_wbck.sv | 127 ++++++++++++
 tb/tb_exu_wbck.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/exu_wbck.sv
// Write-back / commit stage: fixed-priority LSU-over-ALU arbitration into a single
// registered register-file write port, retire counter and sticky ebreak halt.
//
// state | meaning
// ------+----------------------------------------------------------
// RUN   | accepting results, LSU has priority over ALU
// HALT  | ebreak retired; no further accepts, left only via reset
module exu_wbck #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   alu_wbck_i_valid,
  output logic                   alu_wbck_i_ready,
  input  logic [XLEN-1:0]        alu_wbck_i_wdat,
  input  logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx,
  input  logic                   alu_wbck_i_rdwen,
  input  logic                   alu_wbck_i_ebreak,
  input  logic [XLEN-1:0]        alu_wbck_i_pc,

  input  logic                   lsu_wbck_i_valid,
  output logic                   lsu_wbck_i_ready,
  input  logic [XLEN-1:0]        lsu_wbck_i_wdat,
  input  logic [RFIDX_WIDTH-1:0] lsu_wbck_i_rdidx,
  input  logic                   lsu_wbck_i_rdwen,
  input  logic [XLEN-1:0]        lsu_wbck_i_pc,

  output logic                   rf_wbck_ena,
  output logic [RFIDX_WIDTH-1:0] rf_wbck_idx,
  output logic [XLEN-1:0]        rf_wbck_wdat,

  output logic                   cmt_valid,
  output logic [XLEN-1:0]        cmt_pc,
  output logic                   cmt_halt,
  output logic [CNT_WIDTH-1:0]   cmt_minstret
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic                   alu_fire;
  logic                   lsu_fire;
  logic                   fire;
  logic                   sel_ena;
  logic [RFIDX_WIDTH-1:0] sel_idx;
  logic [XLEN-1:0]        sel_wdat;
  logic [XLEN-1:0]        sel_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Readys depend only on state and the competing source, never on their own valid.
  always_comb begin
    state_nxt        = state;
    lsu_wbck_i_ready = 1'b0;
    alu_wbck_i_ready = 1'b0;
    case (state)
      RUN: begin
        lsu_wbck_i_ready = 1'b1;
        alu_wbck_i_ready = ~lsu_wbck_i_valid;
        if (alu_wbck_i_valid && !lsu_wbck_i_valid && alu_wbck_i_ebreak) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign lsu_fire = lsu_wbck_i_valid & lsu_wbck_i_ready;
  assign alu_fire = alu_wbck_i_valid & alu_wbck_i_ready;
  assign fire     = lsu_fire | alu_fire;

  always_comb begin
    if (lsu_fire) begin
      sel_ena  = lsu_wbck_i_rdwen & (lsu_wbck_i_rdidx != '0);
      sel_idx  = lsu_wbck_i_rdidx;
      sel_wdat = lsu_wbck_i_wdat;
      sel_pc   = lsu_wbck_i_pc;
    end else begin
      sel_ena  = alu_wbck_i_rdwen & (alu_wbck_i_rdidx != '0) & ~alu_wbck_i_ebreak;
      sel_idx  = alu_wbck_i_rdidx;
      sel_wdat = alu_wbck_i_wdat;
      sel_pc   = alu_wbck_i_pc;
    end
  end

  // Payload fields hold their last value across idle cycles; only the strobes clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wbck_ena  <= 1'b0;
      rf_wbck_idx  <= '0;
      rf_wbck_wdat <= '0;
      cmt_valid    <= 1'b0;
      cmt_pc       <= '0;
      cmt_minstret <= '0;
    end else begin
      rf_wbck_ena <= fire & sel_ena;
      cmt_valid   <= fire;
      if (fire) begin
        rf_wbck_idx  <= sel_idx;
        rf_wbck_wdat <= sel_wdat;
        cmt_pc       <= sel_pc;
        cmt_minstret <= cmt_minstret + CNT_WIDTH'(1);
      end
    end
  end

  assign cmt_halt = (state == HALT);

endmodule

// File: tb/tb_exu_wbck.sv
// Scoreboard bench for exu_wbck: a reference model queues expected retirements at
// each clock edge and the negedge monitor pops and compares them against the DUT.
module tb_exu_wbck;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, alu_ready;
  logic [31:0] alu_wdat = '0;
  logic [4:0]  alu_rdidx = '0;
  logic        alu_rdwen = 1'b0, alu_ebreak = 1'b0;
  logic [31:0] alu_pc = '0;
  logic        lsu_valid = 1'b0, lsu_ready;
  logic [31:0] lsu_wdat = '0;
  logic [4:0]  lsu_rdidx = '0;
  logic        lsu_rdwen = 1'b0;
  logic [31:0] lsu_pc = '0;
  logic        rf_ena;
  logic [4:0]  rf_idx;
  logic [31:0] rf_wdat;
  logic        cmt_valid;
  logic [31:0] cmt_pc;
  logic        cmt_halt;
  logic [63:0] cmt_minstret;

  exu_wbck #(.XLEN(32), .RFIDX_WIDTH(5), .CNT_WIDTH(64)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_wbck_i_valid (alu_valid),
    .alu_wbck_i_ready (alu_ready),
    .alu_wbck_i_wdat  (alu_wdat),
    .alu_wbck_i_rdidx (alu_rdidx),
    .alu_wbck_i_rdwen (alu_rdwen),
    .alu_wbck_i_ebreak(alu_ebreak),
    .alu_wbck_i_pc    (alu_pc),
    .lsu_wbck_i_valid (lsu_valid),
    .lsu_wbck_i_ready (lsu_ready),
    .lsu_wbck_i_wdat  (lsu_wdat),
    .lsu_wbck_i_rdidx (lsu_rdidx),
    .lsu_wbck_i_rdwen (lsu_rdwen),
    .lsu_wbck_i_pc    (lsu_pc),
    .rf_wbck_ena      (rf_ena),
    .rf_wbck_idx      (rf_idx),
    .rf_wbck_wdat     (rf_wdat),
    .cmt_valid        (cmt_valid),
    .cmt_pc           (cmt_pc),
    .cmt_halt         (cmt_halt),
    .cmt_minstret     (cmt_minstret)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic [4:0]  idx;
    logic [31:0] wdat;
    logic [31:0] pc;
    logic [63:0] cnt;
  } item_t;

  item_t       sb[$];
  logic [63:0] m_cnt = '0;
  logic        m_halt = 1'b0;
  int          nvec = 0;
  int          nerr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: decides acceptance from the rules, not from DUT readys.
  always @(posedge clk or negedge rst_n) begin
    item_t it;
    if (!rst_n) begin
      sb.delete();
      m_cnt  = '0;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (lsu_valid) begin
        m_cnt  = m_cnt + 64'd1;
        it.ena = lsu_rdwen && (lsu_rdidx != 5'd0);
        it.idx = lsu_rdidx; it.wdat = lsu_wdat; it.pc = lsu_pc; it.cnt = m_cnt;
        sb.push_back(it);
      end else if (alu_valid) begin
        m_cnt  = m_cnt + 64'd1;
        it.ena = alu_rdwen && (alu_rdidx != 5'd0) && !alu_ebreak;
        it.idx = alu_rdidx; it.wdat = alu_wdat; it.pc = alu_pc; it.cnt = m_cnt;
        sb.push_back(it);
        if (alu_ebreak) m_halt = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    item_t it;
    check("cmt_valid", {63'd0, cmt_valid}, {63'd0, sb.size() != 0});
    check("cmt_halt", {63'd0, cmt_halt}, {63'd0, m_halt});
    check("lsu_ready", {63'd0, lsu_ready}, {63'd0, !m_halt});
    check("alu_ready", {63'd0, alu_ready}, {63'd0, !m_halt && !lsu_valid});
    if (sb.size() != 0) begin
      it = sb.pop_front();
      check("rf_ena", {63'd0, rf_ena}, {63'd0, it.ena});
      check("rf_idx", {59'd0, rf_idx}, {59'd0, it.idx});
      check("rf_wdat", {32'd0, rf_wdat}, {32'd0, it.wdat});
      check("cmt_pc", {32'd0, cmt_pc}, {32'd0, it.pc});
      check("minstret", cmt_minstret, it.cnt);
    end else begin
      check("rf_ena_idle", {63'd0, rf_ena}, 64'd0);
      check("minstret_idle", cmt_minstret, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; lsu_valid = 1'b0; alu_ebreak = 1'b0;
  endtask

  task automatic set_alu(input logic [4:0] idx, input logic [31:0] d, input logic [31:0] pc,
                         input logic wen, input logic eb);
    alu_valid = 1'b1; alu_rdidx = idx; alu_wdat = d; alu_pc = pc;
    alu_rdwen = wen; alu_ebreak = eb;
  endtask

  task automatic set_lsu(input logic [4:0] idx, input logic [31:0] d, input logic [31:0] pc,
                         input logic wen);
    lsu_valid = 1'b1; lsu_rdidx = idx; lsu_wdat = d; lsu_pc = pc; lsu_rdwen = wen;
  endtask

  // Asserts reset away from both clock edges and checks the clear is immediate.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_ena", {63'd0, rf_ena}, 64'd0);
    check("rst_idx", {59'd0, rf_idx}, 64'd0);
    check("rst_wdat", {32'd0, rf_wdat}, 64'd0);
    check("rst_valid", {63'd0, cmt_valid}, 64'd0);
    check("rst_pc", {32'd0, cmt_pc}, 64'd0);
    check("rst_halt", {63'd0, cmt_halt}, 64'd0);
    check("rst_minstret", cmt_minstret, 64'd0);
    check("rst_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    check("rst_alu_ready", {63'd0, alu_ready}, {63'd0, !lsu_valid});
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
  endtask

  initial begin
    idle();
    do_reset();

    set_alu(5'd5, 32'h1234_5678, 32'h8000_0000, 1'b1, 1'b0);
    step(); idle(); step();

    set_lsu(5'd3, 32'hAA, 32'h8000_0004, 1'b1);
    set_alu(5'd4, 32'hBB, 32'h8000_0008, 1'b1, 1'b0);
    step(); lsu_valid = 1'b0;
    step(); idle(); step();

    set_alu(5'd0, 32'hDEAD_BEEF, 32'h8000_000C, 1'b1, 1'b0);
    step();
    set_lsu(5'd7, 32'h5555_0000, 32'h8000_0010, 1'b0);
    step();
    set_lsu(5'd0, 32'h0000_1111, 32'h8000_0014, 1'b1);
    step(); idle(); step();

    for (int i = 0; i < 100; i++) begin
      set_alu(5'(1 + i % 31), 32'hC000_0000 + i, 32'h8000_1000 + 4 * i, 1'b1, 1'b0);
      step();
    end
    idle(); step();

    // Random mix; a stalled ALU result keeps its payload until accepted.
    for (int i = 0; i < 200; i++) begin
      if (!(alu_valid && lsu_valid)) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_rdidx = 5'($urandom);
        alu_wdat  = $urandom;
        alu_pc    = $urandom;
        alu_rdwen = 1'($urandom_range(0, 1));
      end
      lsu_valid = ($urandom_range(0, 2) == 0);
      lsu_rdidx = 5'($urandom);
      lsu_wdat  = $urandom;
      lsu_pc    = $urandom;
      lsu_rdwen = 1'($urandom_range(0, 1));
      step();
    end
    idle(); step();

    set_alu(5'd9, 32'h9999, 32'h8000_2000, 1'b1, 1'b0);
    step(); idle();
    do_reset();

    set_alu(5'd2, 32'h2222, 32'h8000_000C, 1'b1, 1'b0);
    step();
    set_alu(5'd1, 32'h1, 32'h8000_0010, 1'b1, 1'b1);
    step(); idle(); step();
    for (int i = 0; i < 6; i++) begin
      set_lsu(5'(i + 1), 32'h7000 + i, 32'h9000_0000 + i, 1'b1);
      set_alu(5'(i + 8), 32'h8000 + i, 32'h9100_0000 + i, 1'b1, 1'b0);
      step();
    end
    idle(); step();
    do_reset();

    set_alu(5'd6, 32'h6666, 32'h8000_3000, 1'b1, 1'b0);
    step(); idle(); step(); step();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
